// File: rtl/uart_cmd_slave.sv
// UART command responder: decodes 2-byte write and 1-byte read command frames
// from rx, drives a simple register bus and returns read data as one byte on tx.
module uart_cmd_slave #(
  parameter int unsigned CLKS_PER_BIT    = 434,
  parameter int unsigned SAMPLE_POINT    = 216,
  parameter int unsigned TURNAROUND_CLKS = 434,
  parameter int unsigned WR_TIMEOUT_CLKS = 4340
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       frame_err
);

  localparam int unsigned BIT_W   = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned AUX_MAX = (TURNAROUND_CLKS > WR_TIMEOUT_CLKS) ? TURNAROUND_CLKS
                                                                        : WR_TIMEOUT_CLKS;
  localparam int unsigned AUX_W   = $clog2(AUX_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RX_START, S_RX_DATA, S_RX_CHECK, S_RX_STOP, S_DECODE, S_WR_WAIT,
    S_RD_CAP, S_TURN, S_TX_START, S_TX_DATA, S_TX_CHECK, S_TX_STOP
  } state_t;

  state_t           state, state_d;
  logic             rx_meta, rx_sync, rx_prev;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic [AUX_W-1:0] aux_cnt, aux_cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       rx_byte, rx_byte_d;
  logic [7:0]       tx_byte, tx_byte_d;
  logic             par_err, par_err_d;
  logic             stop_bit, stop_bit_d;
  logic             wr_pend, wr_pend_d;
  logic [6:0]       reg_addr_d;
  logic [7:0]       reg_wdata_d;
  logic             wr_en_d, rd_en_d, err_d, tx_d;
  logic             fall, at_sample, bit_wrap, bit_en;

  assign fall      = rx_prev & ~rx_sync;
  assign at_sample = (bit_cnt == BIT_W'(SAMPLE_POINT));
  assign bit_wrap  = (bit_cnt == BIT_W'(CLKS_PER_BIT - 1));
  assign bit_en    = (state inside {S_RX_START, S_RX_DATA, S_RX_CHECK, S_RX_STOP,
                                    S_TX_START, S_TX_DATA, S_TX_CHECK, S_TX_STOP});

  // rx synchronizer and edge register, idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      aux_cnt   <= '0;
      idx       <= '0;
      rx_byte   <= '0;
      tx_byte   <= '0;
      par_err   <= 1'b0;
      stop_bit  <= 1'b0;
      wr_pend   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      aux_cnt   <= aux_cnt_d;
      idx       <= idx_d;
      rx_byte   <= rx_byte_d;
      tx_byte   <= tx_byte_d;
      par_err   <= par_err_d;
      stop_bit  <= stop_bit_d;
      wr_pend   <= wr_pend_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_wr_en <= wr_en_d;
      reg_rd_en <= rd_en_d;
      frame_err <= err_d;
      tx        <= tx_d;
    end
  end

  always_comb begin
    state_d     = state;
    bit_cnt_d   = '0;
    aux_cnt_d   = '0;
    idx_d       = idx;
    rx_byte_d   = rx_byte;
    tx_byte_d   = tx_byte;
    par_err_d   = par_err;
    stop_bit_d  = stop_bit;
    wr_pend_d   = wr_pend;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    err_d       = 1'b0;
    tx_d        = 1'b1;

    if (bit_en) bit_cnt_d = bit_wrap ? '0 : bit_cnt + BIT_W'(1);
    // aux counter starts at DECODE so turnaround and timeout include DECODE/RD_CAP
    if (state inside {S_DECODE, S_RD_CAP, S_TURN, S_WR_WAIT}) aux_cnt_d = aux_cnt + AUX_W'(1);

    case (state)
      S_IDLE: if (fall) state_d = S_RX_START;
      S_RX_START: begin
        if (at_sample && rx_sync) state_d = S_IDLE;
        else if (bit_wrap) begin
          state_d = S_RX_DATA;
          idx_d   = '0;
        end
      end
      S_RX_DATA: begin
        if (at_sample) rx_byte_d = {rx_sync, rx_byte[7:1]};
        if (bit_wrap) begin
          idx_d = idx + 3'd1;
          if (idx == 3'd7) state_d = S_RX_CHECK;
        end
      end
      S_RX_CHECK: begin
        if (at_sample) par_err_d = (rx_sync != ~^rx_byte);
        if (bit_wrap) state_d = S_RX_STOP;
      end
      S_RX_STOP: begin
        if (at_sample) begin
          stop_bit_d = rx_sync;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (par_err || !stop_bit) begin
          err_d     = 1'b1;
          wr_pend_d = 1'b0;
        end else if (wr_pend) begin
          reg_wdata_d = rx_byte;
          wr_en_d     = 1'b1;
          wr_pend_d   = 1'b0;
        end else if (rx_byte[7]) begin
          reg_addr_d = rx_byte[6:0];
          wr_pend_d  = 1'b1;
          state_d    = S_WR_WAIT;
        end else begin
          reg_addr_d = rx_byte[6:0];
          rd_en_d    = 1'b1;
          state_d    = S_RD_CAP;
        end
      end
      S_WR_WAIT: begin
        if (fall) state_d = S_RX_START;
        else if (aux_cnt == AUX_W'(WR_TIMEOUT_CLKS - 1)) begin
          err_d     = 1'b1;
          wr_pend_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_RD_CAP: begin
        tx_byte_d = reg_rdata;
        state_d   = S_TURN;
      end
      S_TURN: if (aux_cnt == AUX_W'(TURNAROUND_CLKS - 2)) state_d = S_TX_START;
      S_TX_START: begin
        if (bit_wrap) begin
          state_d = S_TX_DATA;
          idx_d   = '0;
        end
      end
      S_TX_DATA: begin
        if (bit_wrap) begin
          idx_d = idx + 3'd1;
          if (idx == 3'd7) state_d = S_TX_CHECK;
        end
      end
      S_TX_CHECK: if (bit_wrap) state_d = S_TX_STOP;
      S_TX_STOP:  if (bit_wrap) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // tx is registered from the next state so the line changes with the state
    case (state_d)
      S_TX_START: tx_d = 1'b0;
      S_TX_DATA:  tx_d = tx_byte_d[idx_d];
      S_TX_CHECK: tx_d = ~^tx_byte_d;
      default:    tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Bench for uart_cmd_slave: drives UART command frames on rx and checks the
// register bus strobes and the tx response against a frame-level model.
module tb_uart_cmd_slave;

  localparam int unsigned CPB      = 434;
  localparam int unsigned SP       = 216;
  localparam int unsigned TURN     = 434;
  localparam int unsigned WTO      = 4340;
  // start drive -> stop-bit sample: 3 sync cycles + 10 full bits + sample point
  localparam int          STOP_LAT = 3 + 10 * CPB + SP;
  localparam int          RESP_LAT = STOP_LAT + TURN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic       reg_wr_en, reg_rd_en, frame_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int n_vec = 0;
  int n_bad = 0;

  uart_cmd_slave #(
    .CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP), .TURNAROUND_CLKS(TURN), .WR_TIMEOUT_CLKS(WTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor: counts strobe-high cycles and captures the bus at each strobe
  int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0, err_cyc = 0;
  logic [6:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
    if (reg_rd_en === 1'b1) begin rd_cnt++; rd_addr = reg_addr; end
    if (frame_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
  end

  task automatic send_byte(input logic [7:0] b, input logic bad_par, output int k);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    @(negedge clk);
    k = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // send a read command and capture the bus strobe and the tx response frame
  task automatic do_read(input logic [7:0] cmd, input logic [7:0] rdata,
                         output int n_rd, output int n_other, output logic [6:0] addr,
                         output int lat, output logic [10:0] frame);
    int k, rd0, oth0, budget;
    reg_rdata = rdata;
    rd0  = rd_cnt;
    oth0 = wr_cnt + err_cnt;
    send_byte(cmd, 1'b0, k);
    budget = 4 * CPB;
    while (tx !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    lat = (tx === 1'b0) ? cyc - k : -1;
    for (int j = 0; j < 11; j++) begin
      if (j == 0) repeat (CPB / 2) @(negedge clk);
      else repeat (CPB) @(negedge clk);
      frame[j] = tx;
    end
    repeat (CPB) @(negedge clk);
    n_rd    = rd_cnt - rd0;
    n_other = wr_cnt + err_cnt - oth0;
    addr    = rd_addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_vec++; if (reg_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
    n_vec++; if (reg_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", reg_rd_en); end
    n_vec++; if (reg_addr !== 7'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", reg_addr); end
    n_vec++; if (reg_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
    n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_bad++; $display("FAIL post_reset_tx: got %b want 1", tx); end
  endtask

  task automatic test_write();
    int k, wr0, rd0, er0;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    send_byte(8'h85, 1'b0, k);
    repeat (100) @(negedge clk);
    send_byte(8'h3C, 1'b0, k);
    repeat (20) @(negedge clk);
    n_vec++; if (wr_cnt - wr0 != 1) begin n_bad++; $display("FAIL write_strobe: got %0d want 1", wr_cnt - wr0); end
    n_vec++; if (wr_addr !== 7'h05) begin n_bad++; $display("FAIL write_addr: got %h want 05", wr_addr); end
    n_vec++; if (wr_data !== 8'h3C) begin n_bad++; $display("FAIL write_data: got %h want 3c", wr_data); end
    n_vec++; if (err_cnt - er0 != 0) begin n_bad++; $display("FAIL write_err: got %0d want 0", err_cnt - er0); end
    n_vec++; if (rd_cnt - rd0 != 0) begin n_bad++; $display("FAIL write_rd: got %0d want 0", rd_cnt - rd0); end
    n_vec++; if (reg_addr !== 7'h05) begin n_bad++; $display("FAIL write_addr_hold: got %h want 05", reg_addr); end
  endtask

  task automatic test_read();
    int n_rd, n_oth, lat;
    logic [6:0]  addr;
    logic [10:0] frame;
    do_read(8'h12, 8'hA7, n_rd, n_oth, addr, lat, frame);
    n_vec++; if (n_rd != 1) begin n_bad++; $display("FAIL read_strobe: got %0d want 1", n_rd); end
    n_vec++; if (addr !== 7'h12) begin n_bad++; $display("FAIL read_addr: got %h want 12", addr); end
    n_vec++; if (lat != RESP_LAT) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", lat, RESP_LAT); end
    n_vec++; if (frame !== 11'b1_0_10100111_0) begin n_bad++; $display("FAIL read_frame: got %b want %b", frame, 11'b1_0_10100111_0); end
    n_vec++; if (n_oth != 0) begin n_bad++; $display("FAIL read_other: got %0d want 0", n_oth); end
  endtask

  task automatic test_parity_error();
    int k, wr0, er0, n_rd, n_oth, lat;
    logic [6:0]  a, addr;
    logic [7:0]  d;
    logic [10:0] frame;
    wr0 = wr_cnt; er0 = err_cnt;
    send_byte(8'h85, 1'b1, k);
    repeat (20) @(negedge clk);
    n_vec++; if (err_cnt - er0 != 1) begin n_bad++; $display("FAIL parity_err: got %0d want 1", err_cnt - er0); end
    n_vec++; if (wr_cnt - wr0 != 0) begin n_bad++; $display("FAIL parity_wr: got %0d want 0", wr_cnt - wr0); end
    a = 7'($urandom_range(0, 127));
    d = 8'($urandom_range(0, 255));
    do_read({1'b0, a}, d, n_rd, n_oth, addr, lat, frame);
    n_vec++; if (n_rd != 1) begin n_bad++; $display("FAIL parity_read_strobe: got %0d want 1", n_rd); end
    n_vec++; if (addr !== a) begin n_bad++; $display("FAIL parity_read_addr: got %h want %h", addr, a); end
    n_vec++; if (lat != RESP_LAT) begin n_bad++; $display("FAIL parity_read_latency: got %0d want %0d", lat, RESP_LAT); end
    n_vec++; if (frame !== {1'b1, ~^d, d, 1'b0}) begin n_bad++; $display("FAIL parity_read_frame: got %b want %b", frame, {1'b1, ~^d, d, 1'b0}); end
  endtask

  task automatic test_timeout();
    int k, wr0, er0, n_rd, n_oth, lat, dt;
    logic [6:0]  addr;
    logic [7:0]  d;
    logic [10:0] frame;
    wr0 = wr_cnt; er0 = err_cnt;
    send_byte(8'h85, 1'b0, k);
    repeat (5000) @(negedge clk);
    dt = err_cyc - k;
    n_vec++; if (err_cnt - er0 != 1) begin n_bad++; $display("FAIL timeout_err: got %0d want 1", err_cnt - er0); end
    // error nominally WTO cycles after the stop-bit sample (DECODE included)
    n_vec++; if (dt < STOP_LAT + WTO - 3 || dt > STOP_LAT + WTO + 3) begin
      n_bad++; $display("FAIL timeout_time: got %0d want %0d +-3", dt, STOP_LAT + WTO);
    end
    n_vec++; if (wr_cnt - wr0 != 0) begin n_bad++; $display("FAIL timeout_wr: got %0d want 0", wr_cnt - wr0); end
    d = 8'($urandom_range(0, 255));
    do_read(8'h3C, d, n_rd, n_oth, addr, lat, frame);
    n_vec++; if (n_rd != 1) begin n_bad++; $display("FAIL timeout_read_strobe: got %0d want 1", n_rd); end
    n_vec++; if (addr !== 7'h3C) begin n_bad++; $display("FAIL timeout_read_addr: got %h want 3c", addr); end
    n_vec++; if (frame !== {1'b1, ~^d, d, 1'b0}) begin n_bad++; $display("FAIL timeout_read_frame: got %b want %b", frame, {1'b1, ~^d, d, 1'b0}); end
    n_vec++; if (n_oth != 0) begin n_bad++; $display("FAIL timeout_read_other: got %0d want 0", n_oth); end
  endtask

  task automatic test_glitch();
    int wr0, rd0, er0;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    n_vec++; if (wr_cnt + rd_cnt - wr0 - rd0 != 0) begin n_bad++; $display("FAIL glitch_strobe: got %0d want 0", wr_cnt + rd_cnt - wr0 - rd0); end
    n_vec++; if (err_cnt - er0 != 0) begin n_bad++; $display("FAIL glitch_err: got %0d want 0", err_cnt - er0); end
    n_vec++; if (tx !== 1'b1) begin n_bad++; $display("FAIL glitch_tx: got %b want 1", tx); end
  endtask

  task automatic test_reset_mid_response();
    int k, budget, lows;
    reg_rdata = 8'($urandom_range(0, 255));
    send_byte({1'b0, 7'($urandom_range(0, 127))}, 1'b0, k);
    budget = 4 * CPB;
    while (tx !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_vec++; if (tx !== 1'b0) begin n_bad++; $display("FAIL midresp_start: got %b want 0", tx); end
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (tx !== 1'b1) begin n_bad++; $display("FAIL midresp_async_tx: got %b want 1", tx); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_vec++; if (lows != 0) begin n_bad++; $display("FAIL midresp_idle: got %0d low cycles want 0", lows); end
  endtask

  task automatic test_random_write();
    int k, wr0, rd0, er0, gap;
    logic [6:0] a;
    logic [7:0] d;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    a   = 7'($urandom_range(0, 127));
    d   = 8'($urandom_range(0, 255));
    gap = int'($urandom_range(0, 2000));
    send_byte({1'b1, a}, 1'b0, k);
    repeat (gap) @(negedge clk);
    send_byte(d, 1'b0, k);
    repeat (20) @(negedge clk);
    n_vec++; if (wr_cnt - wr0 != 1) begin n_bad++; $display("FAIL rwrite_strobe: got %0d want 1", wr_cnt - wr0); end
    n_vec++; if (wr_addr !== a) begin n_bad++; $display("FAIL rwrite_addr: got %h want %h", wr_addr, a); end
    n_vec++; if (wr_data !== d) begin n_bad++; $display("FAIL rwrite_data: got %h want %h", wr_data, d); end
    n_vec++; if (err_cnt + rd_cnt - er0 - rd0 != 0) begin n_bad++; $display("FAIL rwrite_other: got %0d want 0", err_cnt + rd_cnt - er0 - rd0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_parity_error();
    test_timeout();
    test_glitch();
    test_reset_mid_response();
    test_random_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
